// File: rtl/demux_stream.sv
// Registered valid/ready 1-to-N demultiplexer with one holding register per channel.
// Words are steered by ctrl (MODE 0) or by a rotating pointer (MODE 1).
module demux_stream #(
    parameter int SIZE_CTRL = 2,
    parameter int WIRE      = 1,
    parameter int MODE      = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SIZE_CTRL-1:0]           ctrl,
    input  logic                           in_valid,
    input  logic [WIRE-1:0]                in,
    output logic                           in_ready,
    output logic [(2**SIZE_CTRL)-1:0]      out_valid,
    output logic [(2**SIZE_CTRL)*WIRE-1:0] out,
    input  logic [(2**SIZE_CTRL)-1:0]      out_ready,
    output logic [SIZE_CTRL-1:0]           sel
);

    localparam int N = 2**SIZE_CTRL;

    logic [N-1:0][WIRE-1:0] data_r;
    logic [N-1:0]           full_r;
    logic [SIZE_CTRL-1:0]   rr_r;
    logic [SIZE_CTRL-1:0]   target_s;
    logic                   ready_s;
    logic                   accept_s;
    logic [N-1:0]           load_s;
    logic [N-1:0]           drain_s;

    // Target channel selection and input handshake
    always_comb begin
        if (MODE == 1) begin
            target_s = rr_r;
        end else begin
            target_s = ctrl;
        end
        // a slot being drained on this edge can take the new word at once
        ready_s  = !full_r[target_s] || out_ready[target_s];
        accept_s = in_valid && ready_s;
        if (accept_s) begin
            load_s = N'(1) << target_s;
        end else begin
            load_s = {N{1'b0}};
        end
        drain_s = full_r & out_ready;
    end

    assign in_ready  = ready_s;
    assign sel       = target_s;
    assign out_valid = full_r;
    assign out       = data_r;

    // Per-channel holding registers: load wins over drain on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            full_r <= {N{1'b0}};
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load_s[k]) begin
                    data_r[k] <= in;
                    full_r[k] <= 1'b1;
                end else if (drain_s[k]) begin
                    full_r[k] <= 1'b0;
                end else begin
                    full_r[k] <= full_r[k];
                end
            end
        end
    end

    // Round-robin pointer: strict rotation, advances only on an accepted word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= {SIZE_CTRL{1'b0}};
        end else if ((MODE == 1) && accept_s) begin
            rr_r <= rr_r + SIZE_CTRL'(1);
        end else begin
            rr_r <= rr_r;
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: addressed instance (WIRE=1) and round-robin
// instance (WIRE=8) driven side by side against a per-channel queue scoreboard.
module tb_demux_stream;

    logic clk;
    logic rst_n;

    logic [1:0]  a_ctrl;
    logic        a_in_valid;
    logic [0:0]  a_in;
    logic        a_in_ready;
    logic [3:0]  a_out_valid;
    logic [3:0]  a_out;
    logic [3:0]  a_out_ready;
    logic [1:0]  a_sel;

    logic [1:0]  b_ctrl;
    logic        b_in_valid;
    logic [7:0]  b_in;
    logic        b_in_ready;
    logic [3:0]  b_out_valid;
    logic [31:0] b_out;
    logic [3:0]  b_out_ready;
    logic [1:0]  b_sel;

    logic [7:0] qa [4][$];
    logic [7:0] qb [4][$];
    logic [1:0] b_rr;

    int total_cnt;
    int bad_cnt;

    demux_stream #(.SIZE_CTRL(2), .WIRE(1), .MODE(0)) dut_addr (
        .clk(clk), .rst_n(rst_n), .ctrl(a_ctrl), .in_valid(a_in_valid), .in(a_in),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out(a_out),
        .out_ready(a_out_ready), .sel(a_sel)
    );

    demux_stream #(.SIZE_CTRL(2), .WIRE(8), .MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ctrl(b_ctrl), .in_valid(b_in_valid), .in(b_in),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out(b_out),
        .out_ready(b_out_ready), .sel(b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_valid(input int which);
        logic [3:0] v;
        v = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (which == 0) v[k] = (qa[k].size() != 0);
            else            v[k] = (qb[k].size() != 0);
        end
        return v;
    endfunction

    // One clock cycle: check handshake and outputs against the model, then advance
    task automatic tick();
        logic       exp_rdy_a;
        logic       exp_rdy_b;
        logic [7:0] e;
        #1;
        exp_rdy_a = (qa[a_ctrl].size() == 0) || a_out_ready[a_ctrl];
        exp_rdy_b = (qb[b_rr].size() == 0) || b_out_ready[b_rr];
        check_val("a_in_ready", 32'(a_in_ready), 32'(exp_rdy_a));
        check_val("b_in_ready", 32'(b_in_ready), 32'(exp_rdy_b));
        check_val("a_sel", 32'(a_sel), 32'(a_ctrl));
        check_val("b_sel", 32'(b_sel), 32'(b_rr));
        check_val("a_out_valid", 32'(a_out_valid), 32'(model_valid(0)));
        check_val("b_out_valid", 32'(b_out_valid), 32'(model_valid(1)));
        for (int k = 0; k < 4; k++) begin
            if (a_out_valid[k] && a_out_ready[k] && qa[k].size() != 0) begin
                e = qa[k].pop_front();
                check_val("a_drain_data", 32'(a_out[k]), 32'(e));
            end
            if (b_out_valid[k] && b_out_ready[k] && qb[k].size() != 0) begin
                e = qb[k].pop_front();
                check_val("b_drain_data", 32'(b_out[k*8 +: 8]), 32'(e));
            end
        end
        if (a_in_valid && exp_rdy_a) qa[a_ctrl].push_back(8'(a_in));
        if (b_in_valid && exp_rdy_b) begin
            qb[b_rr].push_back(b_in);
            b_rr = b_rr + 2'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            qa[k].delete();
            qb[k].delete();
        end
        b_rr = 2'd0;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_a_ov"}, 32'(a_out_valid), 32'd0);
        check_val({tag, "_a_out"}, 32'(a_out), 32'd0);
        check_val({tag, "_b_ov"}, 32'(b_out_valid), 32'd0);
        check_val({tag, "_b_out"}, b_out, 32'd0);
        check_val({tag, "_b_sel"}, 32'(b_sel), 32'd0);
        check_val({tag, "_a_rdy"}, 32'(a_in_ready), 32'd1);
        check_val({tag, "_b_rdy"}, 32'(b_in_ready), 32'd1);
    endtask

    initial begin
        total_cnt   = 0;
        bad_cnt     = 0;
        rst_n       = 1'b0;
        a_ctrl      = 2'd0;
        a_in_valid  = 1'b0;
        a_in        = 1'b0;
        a_out_ready = 4'hF;
        b_ctrl      = 2'd0;
        b_in_valid  = 1'b0;
        b_in        = 8'h00;
        b_out_ready = 4'hF;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        // addressed sweep, one-hot valid one cycle after each word
        a_in       = 1'b1;
        a_in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            a_ctrl = 2'(c);
            tick();
            check_val("sweep_ov", 32'(a_out_valid), 32'(4'b0001 << c));
            check_val("sweep_slice", 32'(a_out[c]), 32'd1);
        end
        a_in_valid = 1'b0;
        tick();

        // backpressure on channel 2: A=1 held, B=0 waits, then load+drain same edge
        a_out_ready = 4'b1011;
        a_ctrl      = 2'd2;
        a_in_valid  = 1'b1;
        a_in        = 1'b1;
        tick();
        a_in = 1'b0;
        tick();
        tick();
        check_val("bp_held_slice", 32'(a_out[2]), 32'd1);
        check_val("bp_stall_rdy", 32'(a_in_ready), 32'd0);
        a_out_ready = 4'hF;
        tick();
        check_val("bp_ov2", 32'(a_out_valid[2]), 32'd1);
        check_val("bp_b_slice", 32'(a_out[2]), 32'd0);
        a_in_valid = 1'b0;
        tick();

        // independence: channel 1 stalled full, channel 3 still loads
        a_out_ready = 4'b1101;
        a_in_valid  = 1'b1;
        a_in        = 1'b1;
        a_ctrl      = 2'd1;
        tick();
        a_ctrl = 2'd3;
        tick();
        check_val("ind_ov", 32'(a_out_valid), 32'b1010);
        check_val("ind_ch1", 32'(a_out[1]), 32'd1);
        a_in_valid = 1'b0;
        tick();
        check_val("ind_after", 32'(a_out_valid), 32'b0010);
        a_out_ready = 4'hF;
        tick();

        // round-robin wrap: six words land on 0,1,2,3,0,1
        b_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_in   = 8'h10 + 8'(i);
            b_ctrl = 2'(3 - (i % 4));
            tick();
        end
        check_val("rr_wrap_sel", 32'(b_sel), 32'd2);
        check_val("rr_wrap_ch1", 32'(b_out[15:8]), 32'h15);
        b_in_valid = 1'b0;
        tick();

        // round-robin stall: fill around until rr=1 with channel 1 full and stalled
        b_out_ready = 4'b1101;
        b_in_valid  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b_in = 8'h20 + 8'(i);
            tick();
        end
        b_in = 8'h30;
        tick();
        tick();
        check_val("rr_stall_rdy", 32'(b_in_ready), 32'd0);
        check_val("rr_stall_sel", 32'(b_sel), 32'd1);
        b_out_ready = 4'hF;
        tick();
        check_val("rr_resume_sel", 32'(b_sel), 32'd2);
        check_val("rr_resume_ch1", 32'(b_out[15:8]), 32'h30);
        b_in_valid = 1'b0;
        tick();

        // reset mid-operation with channels 0 and 3 full on both instances
        a_out_ready = 4'h0;
        b_out_ready = 4'h0;
        a_in_valid  = 1'b1;
        b_in_valid  = 1'b1;
        a_in        = 1'b1;
        a_ctrl      = 2'd0;
        b_in        = 8'h40;
        tick();
        a_ctrl = 2'd3;
        b_in   = 8'h41;
        tick();
        a_in_valid = 1'b0;
        b_in       = 8'h42;
        tick();
        b_in_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_reset_state("midrst");
        clear_model();
        a_out_ready = 4'hF;
        b_out_ready = 4'hF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_in_valid = 1'b1;
        b_in       = 8'hA5;
        tick();
        check_val("post_rst_ov", 32'(b_out_valid), 32'b0001);
        check_val("post_rst_ch0", 32'(b_out[7:0]), 32'hA5);
        b_in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
# demux_stream

Registered, handshaked 1-to-N demultiplexer: successor of the combinational `demux`, generalised to a valid/ready stream with one holding register per output channel. Each input word is steered either to the channel selected by `ctrl` (addressed mode) or to an internally rotating channel (round-robin mode). It sits between a single producer and N independent consumers that may stall individually.

## Interface
Parameters:
- `SIZE_CTRL`, 2: select width; channel count N = 2**SIZE_CTRL.
- `WIRE`, 1: data width per word.
- `MODE`, 0: 0 = addressed (`ctrl` picks channel), 1 = round-robin (`ctrl` ignored).

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `ctrl`  input  SIZE_CTRL  target channel in MODE 0, sampled with the accepted word.
- `in_valid`  input  1  input word present.
- `in`  input  WIRE  input word.
- `in_ready`  output  1  block accepts the word this cycle.
- `out_valid`  output  N  per-channel word held.
- `out`  output  N*WIRE  channel k occupies bits [k*WIRE +: WIRE].
- `out_ready`  input  N  per-channel consumer accepts.
- `sel`  output  SIZE_CTRL  current target channel (MODE 0: `ctrl`; MODE 1: round-robin pointer).

## Operation
- Target channel t: MODE 0 t = `ctrl`; MODE 1 t = internal pointer `rr`.
- `sel` = t, combinational.
- Per channel k: one register `data[k]` (WIRE bits) and flag `full[k]`; `out_valid[k]` = `full[k]`, `out` slice k = `data[k]`.
- `in_ready` = !`full[t]` | `out_ready[t]` (slot empty or being drained this same cycle).
- Accept = `in_valid` & `in_ready`: on the edge, `data[t]` <= `in`, `full[t]` <= 1.
- Drain of channel k = `full[k]` & `out_ready[k]`: clears `full[k]` unless channel k is also loaded the same edge (then stays 1 with new data).
- Non-target channels drain independently; a stalled channel never blocks the others in MODE 0.
- MODE 1: `rr` advances by 1 on every accept, wraps N-1 -> 0; holds when no accept. A stalled target channel stalls the whole input in MODE 1 (strict rotation, no skipping).
- `out_ready[k]` while `full[k]`=0 has no effect.
- `in` and `ctrl` are don't-care when `in_valid`=0; `in_ready` may be high without `in_valid`.
- Channel k data is stable while `out_valid[k]`=1 and `out_ready[k]`=0.

## Timing
- Latency: word accepted at edge n appears on `out_valid[t]`/`out` slice t after edge n (visible cycle n+1).
- Throughput: 1 word/cycle per channel when consumer holds `out_ready` high (load + drain same edge).
- Reset (`rst_n`=0, asynchronous, immediate): all `full` = 0, all `data` = 0, `rr` = 0; hence `out_valid` = 0, `out` = 0, `sel` = 0 in MODE 1; `in_ready` = 1 during and after reset.
- Reset mid-operation discards held words without handshake; first cycle after release is as from fresh reset.
- `in_ready` depends combinationally on `ctrl`, `out_ready` and state; no combinational path from `in_valid` to `in_ready`.

## Test plan
- Addressed sweep (MODE 0, SIZE_CTRL=2, WIRE=1, all `out_ready`=1): `in`=1, `in_valid`=1, `ctrl`=0,1,2,3 for one cycle each -> `out_valid` = 0001, 0010, 0100, 1000 one cycle later, out slice = 1; `in_ready` constant 1.
- Backpressure: `out_ready[2]`=0, send word A to ctrl=2 then word B to ctrl=2 -> A held on channel 2, `in_ready`=0 on second word; raise `out_ready[2]` -> A drains and B loads same edge, `out_valid[2]` stays 1, slice 2 = B next cycle.
- Independence: channel 1 stalled full, send to ctrl=3 -> `in_ready`=1, channel 3 loads, channel 1 untouched.
- Round-robin wrap (MODE 1, N=4, WIRE=8): 6 accepted words 0x10..0x15 with all ready -> channels 0,1,2,3,0,1; `sel` = 2 after the sixth accept.
- Round-robin stall: MODE 1, `out_ready[1]`=0, channel 1 already full, `rr`=1 -> `in_ready`=0, `rr` holds at 1 until `out_ready[1]`=1.
- Reset mid-operation: channels 0 and 3 full, assert `rst_n`=0 between edges -> `out_valid`=0000, `out`=0 immediately, `rr`=0; after release first word lands on channel 0 (MODE 1).
